// File: rtl/axis_master_tx.sv
// ============================================================================
// Module      : axis_master_tx
// Description : AXI4-Stream master transmitter. It buffers local push beats in
//               a small FIFO and latches frame sideband (ID/DEST/USER) once per
//               frame. Optional macro AXIS_TX_STATS_EN adds transfer counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_master_tx #(
  parameter int NUM_BYTES  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [8*NUM_BYTES-1:0]         in_data,
  input  logic [NUM_BYTES-1:0]           in_keep,
  input  logic                           in_last,
  input  logic [7:0]                     in_id,
  input  logic [3:0]                     in_dest,
  input  logic [16:0]                    in_user,
  output logic                           TVALID,
  input  logic                           TREADY,
  output logic [8*NUM_BYTES-1:0]         TDATA,
  output logic [NUM_BYTES-1:0]           TSTRB,
  output logic [NUM_BYTES-1:0]           TKEEP,
  output logic                           TLAST,
  output logic [7:0]                     TID,
  output logic [3:0]                     TDEST,
  output logic [16:0]                    TUSER,
  output logic                           busy,
`ifdef AXIS_TX_STATS_EN
  output logic [15:0]                    tx_frames,
  output logic [31:0]                    tx_beats,
`endif
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  // Open frames: up to FIFO_DEPTH stored frames plus one still arriving.
  localparam int FW = $clog2(FIFO_DEPTH + 2);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_IN_FRAME = 1'b1;

  logic [0:0]             state;
  logic [7:0]             sb_id;
  logic [3:0]             sb_dest;
  logic [16:0]            sb_user;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [LW-1:0]          count;
  logic [LW-1:0]          count_nxt;
  logic                   full;
  logic                   rdy_en;
  logic [FW-1:0]          frames_open;

  logic [8*NUM_BYTES-1:0] mem_data [FIFO_DEPTH];
  logic [NUM_BYTES-1:0]   mem_keep [FIFO_DEPTH];
  logic                   mem_last [FIFO_DEPTH];
  logic [7:0]             mem_id   [FIFO_DEPTH];
  logic [3:0]             mem_dest [FIFO_DEPTH];
  logic [16:0]            mem_user [FIFO_DEPTH];

  logic                   accept;
  logic                   null_beat;
  logic                   push;
  logic                   pop;
  logic                   frame_start;
  logic                   frame_end;
  logic [8*NUM_BYTES-1:0] in_data_masked;
  logic [7:0]             cur_id;
  logic [3:0]             cur_dest;
  logic [16:0]            cur_user;

  // in_ready is derived only from registered state, never from TREADY.
  assign in_ready    = rdy_en & ~full;
  assign accept      = in_valid & in_ready;
  assign null_beat   = (in_keep == '0) & ~in_last;
  assign push        = accept & ~null_beat;
  assign pop         = TVALID & TREADY;
  assign frame_start = accept & (state == ST_IDLE);
  assign frame_end   = pop & TLAST;

  assign cur_id   = (state == ST_IDLE) ? in_id   : sb_id;
  assign cur_dest = (state == ST_IDLE) ? in_dest : sb_dest;
  assign cur_user = (state == ST_IDLE) ? in_user : sb_user;

  always_comb begin
    in_data_masked = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (in_keep[b]) begin
        in_data_masked[8*b +: 8] = in_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + LW'(1);
      2'b01:   count_nxt = count - LW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= ST_IDLE;
      sb_id   <= '0;
      sb_dest <= '0;
      sb_user <= '0;
    end else if (accept) begin
      if (state == ST_IDLE) begin
        sb_id   <= in_id;
        sb_dest <= in_dest;
        sb_user <= in_user;
      end
      state <= in_last ? ST_IDLE : ST_IN_FRAME;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      count  <= count_nxt;
      full   <= (count_nxt == LW'(FIFO_DEPTH));
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Storage holds no reset: outputs are gated by TVALID instead.
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_data[wr_ptr] <= in_data_masked;
      mem_keep[wr_ptr] <= in_keep;
      mem_last[wr_ptr] <= in_last;
      mem_id[wr_ptr]   <= cur_id;
      mem_dest[wr_ptr] <= cur_dest;
      mem_user[wr_ptr] <= cur_user;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      frames_open <= '0;
    end else begin
      case ({frame_start, frame_end})
        2'b10:   frames_open <= frames_open + FW'(1);
        2'b01:   frames_open <= frames_open - FW'(1);
        default: frames_open <= frames_open;
      endcase
    end
  end

  assign busy       = (frames_open != '0);
  assign fifo_level = count;
  assign TVALID     = (count != '0);
  assign TSTRB      = TKEEP;

  always_comb begin
    TDATA = '0;
    TKEEP = '0;
    TLAST = 1'b0;
    TID   = '0;
    TDEST = '0;
    TUSER = '0;
    if (TVALID) begin
      TDATA = mem_data[rd_ptr];
      TKEEP = mem_keep[rd_ptr];
      TLAST = mem_last[rd_ptr];
      TID   = mem_id[rd_ptr];
      TDEST = mem_dest[rd_ptr];
      TUSER = mem_user[rd_ptr];
    end
  end

`ifdef AXIS_TX_STATS_EN
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      tx_frames <= '0;
      tx_beats  <= '0;
    end else if (pop) begin
      tx_beats <= tx_beats + 32'd1;
      if (TLAST) begin
        tx_frames <= tx_frames + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_master_tx.sv
// ============================================================================
// Module      : tb_axis_master_tx
// Description : Scoreboard bench for axis_master_tx (NUM_BYTES=4, FIFO_DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_master_tx;

  localparam int NB    = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [7:0]  id;
    logic [3:0]  dest;
    logic [16:0] user;
  } beat_t;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic [3:0]    in_keep = '0;
  logic          in_last = 1'b0;
  logic [7:0]    in_id = '0;
  logic [3:0]    in_dest = '0;
  logic [16:0]   in_user = '0;
  logic          TVALID;
  logic          TREADY = 1'b0;
  logic [31:0]   TDATA;
  logic [3:0]    TSTRB;
  logic [3:0]    TKEEP;
  logic          TLAST;
  logic [7:0]    TID;
  logic [3:0]    TDEST;
  logic [16:0]   TUSER;
  logic          busy;
  logic [2:0]    fifo_level;
`ifdef AXIS_TX_STATS_EN
  logic [15:0]   tx_frames;
  logic [31:0]   tx_beats;
`endif

  axis_master_tx #(.NUM_BYTES(NB), .FIFO_DEPTH(DEPTH)) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_keep    (in_keep),
    .in_last    (in_last),
    .in_id      (in_id),
    .in_dest    (in_dest),
    .in_user    (in_user),
    .TVALID     (TVALID),
    .TREADY     (TREADY),
    .TDATA      (TDATA),
    .TSTRB      (TSTRB),
    .TKEEP      (TKEEP),
    .TLAST      (TLAST),
    .TID        (TID),
    .TDEST      (TDEST),
    .TUSER      (TUSER),
    .busy       (busy),
`ifdef AXIS_TX_STATS_EN
    .tx_frames  (tx_frames),
    .tx_beats   (tx_beats),
`endif
    .fifo_level (fifo_level)
  );

  always #5 ACLK = ~ACLK;

  int    n_vec  = 0;
  int    n_miss = 0;
  int    popped = 0;
  beat_t sb[$];

  logic        exp_in_frame = 1'b0;
  logic [7:0]  lat_id   = '0;
  logic [3:0]  lat_dest = '0;
  logic [16:0] lat_user = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mask_data(input logic [31:0] d, input logic [3:0] k);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      if (k[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  // Scoreboard: compare every handshake against the oldest expected beat.
  always @(negedge ACLK) begin
    if (ARESETn && TVALID && TREADY) begin
      beat_t e;
      check_eq("sb_underflow", 64'(sb.size() == 0), 64'd0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("tdata", TDATA, e.data);
        check_eq("tkeep", TKEEP, e.keep);
        check_eq("tstrb", TSTRB, e.keep);
        check_eq("tlast", TLAST, e.last);
        check_eq("tid",   TID,   e.id);
        check_eq("tdest", TDEST, e.dest);
        check_eq("tuser", TUSER, e.user);
        popped++;
      end
    end
  end

  task automatic push_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                           input logic [7:0] id, input logic [3:0] de, input logic [16:0] u);
    beat_t e;
    int    w;
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    in_id    = id;
    in_dest  = de;
    in_user  = u;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge ACLK); #1;
      w++;
    end
    if (w >= 200) begin
      check_eq("push_timeout", 64'(w), 64'd0);
      in_valid = 1'b0;
    end else begin
      @(posedge ACLK); #1;
      in_valid = 1'b0;
      if (!exp_in_frame) begin
        lat_id   = id;
        lat_dest = de;
        lat_user = u;
      end
      e.data = mask_data(d, k);
      e.keep = k;
      e.last = l;
      e.id   = lat_id;
      e.dest = lat_dest;
      e.user = lat_user;
      if (!(k == 4'h0 && !l)) sb.push_back(e);
      exp_in_frame = !l;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(posedge ACLK); #1;
      w++;
    end
    check_eq("drain_left", 64'(sb.size()), 64'd0);
    @(posedge ACLK); #1;
    check_eq("drain_level", fifo_level, 3'd0);
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    #1;
    sb.delete();
    exp_in_frame = 1'b0;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
  endtask

  initial begin
    int p0;
    #2;
    check_eq("rst_tvalid",   TVALID,     1'b0);
    check_eq("rst_in_ready", in_ready,   1'b0);
    check_eq("rst_busy",     busy,       1'b0);
    check_eq("rst_level",    fifo_level, 3'd0);
    check_eq("rst_tdata",    TDATA,      32'd0);
    check_eq("rst_tlast",    TLAST,      1'b0);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    check_eq("ready_before_edge", in_ready, 1'b0);
    @(posedge ACLK); #1;
    check_eq("ready_after_edge", in_ready, 1'b1);

    // 3-beat frame; sideband changes after beat 1 must be ignored
    TREADY = 1'b1;
    push_beat(32'h11111111, 4'hF, 1'b0, 8'h5A, 4'h3, 17'h1ABCD);
    check_eq("latency_tvalid", TVALID, 1'b1);
    check_eq("busy_set", busy, 1'b1);
    push_beat(32'h22222222, 4'hF, 1'b0, 8'hFF, 4'hC, 17'h00001);
    push_beat(32'h33333333, 4'hF, 1'b1, 8'h01, 4'h7, 17'h0F0F0);
    drain();
    check_eq("busy_clear", busy, 1'b0);

    // stall: outputs held while TREADY is low
    TREADY = 1'b0;
    push_beat(32'hCAFEF00D, 4'hF, 1'b1, 8'h77, 4'h9, 17'h12345);
    repeat (5) begin
      @(negedge ACLK);
      check_eq("stall_tvalid", TVALID, 1'b1);
      check_eq("stall_tdata",  TDATA,  32'hCAFEF00D);
      check_eq("stall_tid",    TID,    8'h77);
      check_eq("stall_tlast",  TLAST,  1'b1);
      check_eq("stall_tuser",  TUSER,  17'h12345);
    end
    @(posedge ACLK); #1;
    p0 = popped;
    TREADY = 1'b1;
    drain();
    check_eq("stall_popped", 64'(popped - p0), 64'd1);

    // fill to full, then drain in order
    TREADY = 1'b0;
    p0 = popped;
    for (int i = 0; i < 4; i++)
      push_beat(32'hA0000000 + 32'(i), 4'hF, 1'b0, 8'h42, 4'h1, 17'h00042);
    check_eq("full_in_ready", in_ready,   1'b0);
    check_eq("full_level",    fifo_level, 3'd4);
    TREADY = 1'b1;
    #0;
    check_eq("full_no_comb_ready", in_ready, 1'b0);
    push_beat(32'hA0000004, 4'hF, 1'b0, 8'h99, 4'h2, 17'h00099);
    push_beat(32'hA0000005, 4'hF, 1'b1, 8'h99, 4'h2, 17'h00099);
    drain();
    check_eq("full_popped", 64'(popped - p0), 64'd6);

    // null beat dropped; partial keep masks data; null-last emitted
    p0 = popped;
    push_beat(32'h0A0A0A0A, 4'hF, 1'b0, 8'h33, 4'h4, 17'h00333);
    push_beat(32'h99999999, 4'h0, 1'b0, 8'h33, 4'h4, 17'h00333);
    push_beat(32'h0B0B0B0B, 4'hF, 1'b0, 8'h33, 4'h4, 17'h00333);
    push_beat(32'hDEADBEEF, 4'h3, 1'b1, 8'h33, 4'h4, 17'h00333);
    push_beat(32'h12345678, 4'h0, 1'b1, 8'h44, 4'h5, 17'h00444);
    drain();
    check_eq("null_popped", 64'(popped - p0), 64'd4);

    // reset mid-frame with 2 beats queued
    TREADY = 1'b0;
    push_beat(32'h51515151, 4'hF, 1'b0, 8'h11, 4'h6, 17'h00011);
    push_beat(32'h52525252, 4'hF, 1'b0, 8'h11, 4'h6, 17'h00011);
    check_eq("pre_rst_level", fifo_level, 3'd2);
    #2;
    ARESETn = 1'b0;
    #1;
    check_eq("mid_rst_tvalid", TVALID,     1'b0);
    check_eq("mid_rst_level",  fifo_level, 3'd0);
    check_eq("mid_rst_busy",   busy,       1'b0);
    sb.delete();
    exp_in_frame = 1'b0;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    TREADY = 1'b1;
    push_beat(32'h61616161, 4'hF, 1'b0, 8'h22, 4'hA, 17'h00222);
    push_beat(32'h62626262, 4'hF, 1'b1, 8'h33, 4'hB, 17'h00333);
    drain();

`ifdef AXIS_TX_STATS_EN
    do_reset();
    TREADY = 1'b1;
    for (int f = 0; f < 4; f++) begin
      push_beat(32'h70000000 + 32'(f), 4'hF, 1'b0, 8'(f), 4'h1, 17'h1);
      push_beat(32'h71000000 + 32'(f), 4'hF, 1'b1, 8'(f), 4'h1, 17'h1);
    end
    drain();
    check_eq("tx_frames", tx_frames, 16'd4);
    check_eq("tx_beats",  tx_beats,  32'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
